// File: rtl/pacman_input_pkg.sv
// Shared definitions for the Pacman player-control front end.
// btn_idx_t gives each button its bit position in the per-button vectors;
// lower index means higher arbitration priority.
package pacman_input_pkg;

    localparam int unsigned NUM_BTNS = 5;

    typedef enum logic [2:0] {
        BTN_START = 3'd0,
        BTN_UP    = 3'd1,
        BTN_DOWN  = 3'd2,
        BTN_LEFT  = 3'd3,
        BTN_RIGHT = 3'd4
    } btn_idx_t;

    // One-hot grant of the lowest-index (highest-priority) request bit.
    function automatic logic [NUM_BTNS-1:0] pick_winner(input logic [NUM_BTNS-1:0] req);
        return req & (~req + NUM_BTNS'(1));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button conditioner: polarity normalisation, two-flop synchroniser,
// stability counter and press-edge detect.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   raw_in        unsynchronised button pin
//   stable        debounced level, 1 = pressed (registered)
//   rise_c        combinational, high for the one cycle after stable rises
module button_debounce
    import pacman_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic stable,
    output logic rise_c
);

    localparam int unsigned   CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pressed;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign pressed = ACTIVE_LOW ? ~raw_in : raw_in;

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            count_q       <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            count_q       <= count_d;
        end
    end

    // Accept a level change only after it has differed for DEBOUNCE_CYCLES
    // consecutive evaluations; any agreement restarts the count.
    always_comb begin
        sync1_d       = pressed;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        count_d       = count_q;
        if (sync2_q == stable_q) begin
            count_d = '0;
        end else if (count_q == CNT_MAX) begin
            stable_d = sync2_q;
            count_d  = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign stable = stable_q;
    assign rise_c = stable_q & ~stable_prev_q;

endmodule

// File: rtl/direction_pulse_gen.sv
// Pacman control front end: five debounced buttons, press-edge detect and a
// fixed-priority arbiter producing at most one single-cycle command pulse.
// Ports:
//   clk, reset_n                         clock and asynchronous active-low reset
//   upRaw..startRaw                      unsynchronised button pins
//   upOut..startOut                      registered one-hot press pulses
//   anyHeld                              registered, high while any button is held
module direction_pulse_gen
    import pacman_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic upRaw,
    input  logic downRaw,
    input  logic leftRaw,
    input  logic rightRaw,
    input  logic startRaw,
    output logic upOut,
    output logic downOut,
    output logic leftOut,
    output logic rightOut,
    output logic startOut,
    output logic anyHeld
);

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] stable_vec;
    logic [NUM_BTNS-1:0] rise_vec;
    logic [NUM_BTNS-1:0] pulse_q, pulse_d;
    logic                any_held_q, any_held_d;

    // Pack pins by priority index
    always_comb begin
        raw_vec            = '0;
        raw_vec[BTN_START] = startRaw;
        raw_vec[BTN_UP]    = upRaw;
        raw_vec[BTN_DOWN]  = downRaw;
        raw_vec[BTN_LEFT]  = leftRaw;
        raw_vec[BTN_RIGHT] = rightRaw;
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_in  (raw_vec[i]),
            .stable  (stable_vec[i]),
            .rise_c  (rise_vec[i])
        );
    end

    // Losing rises are dropped; a held button never re-requests.
    always_comb begin
        pulse_d    = pick_winner(rise_vec);
        any_held_d = |stable_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q    <= '0;
            any_held_q <= 1'b0;
        end else begin
            pulse_q    <= pulse_d;
            any_held_q <= any_held_d;
        end
    end

    assign startOut = pulse_q[BTN_START];
    assign upOut    = pulse_q[BTN_UP];
    assign downOut  = pulse_q[BTN_DOWN];
    assign leftOut  = pulse_q[BTN_LEFT];
    assign rightOut = pulse_q[BTN_RIGHT];
    assign anyHeld  = any_held_q;

endmodule
